// File: rtl/cmp_result_tracker.sv
// Downstream consumer of the 2-bit equality comparator: forwards each beat through a
// one-entry output register, keeps saturating statistics, detects equal runs, cross-checks z.
module cmp_result_tracker #(
   parameter int CNT_W   = 8,
   parameter int RUN_LEN = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       x,
   input  logic [1:0]       y,
   input  logic             z,
   input  logic             clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_x,
   output logic [1:0]       out_y,
   output logic             out_eq,
   output logic [CNT_W-1:0] eq_count,
   output logic [CNT_W-1:0] neq_count,
   output logic [CNT_W-1:0] total_count,
   output logic             run_hit,
   output logic             run_active,
   output logic             mismatch_err,
   output logic [1:0]       dbg_state,
   output logic [3:0]       dbg_streak
);

   // Handshake: a beat transfers on any rising edge where valid && ready are both high;
   // valid never waits on ready, data is held while valid && !ready.
   localparam logic [1:0]       ST_IDLE   = 2'd0;
   localparam logic [1:0]       ST_RUN    = 2'd1;
   localparam logic [1:0]       ST_LOCK   = 2'd2;
   localparam logic [3:0]       C_RUN_LEN = 4'(RUN_LEN);
   localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

   logic             r_out_valid;
   logic [1:0]       r_out_x;
   logic [1:0]       r_out_y;
   logic             r_out_eq;
   logic [CNT_W-1:0] r_eq_cnt;
   logic [CNT_W-1:0] r_neq_cnt;
   logic [CNT_W-1:0] r_tot_cnt;
   logic [1:0]       r_state;
   logic [3:0]       r_streak;
   logic             r_run_hit;
   logic             r_mismatch;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_count;
   logic             w_ref_eq;
   logic [1:0]       w_state_nxt;
   logic [3:0]       w_streak_nxt;
   logic             w_hit_nxt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == C_CNT_MAX) ? v : v + 1'b1;
   endfunction

   assign w_in_ready = !r_out_valid || out_ready;
   assign w_accept   = in_valid && w_in_ready;
   // A beat accepted under clr is forwarded only; statistics and FSM ignore it.
   assign w_count    = w_accept && !clr;
   assign w_ref_eq   = (x == y);

   always_comb begin
      w_state_nxt  = r_state;
      w_streak_nxt = r_streak;
      w_hit_nxt    = 1'b0;
      if (w_count) begin
         case (r_state)
            ST_IDLE: begin
               if (z) begin
                  w_streak_nxt = 4'd1;
                  w_state_nxt  = ST_RUN;
               end
            end
            ST_RUN: begin
               if (z) begin
                  if (r_streak + 4'd1 == C_RUN_LEN) begin
                     w_streak_nxt = C_RUN_LEN;
                     w_state_nxt  = ST_LOCK;
                     w_hit_nxt    = 1'b1;
                  end else begin
                     w_streak_nxt = r_streak + 4'd1;
                  end
               end else begin
                  w_streak_nxt = 4'd0;
                  w_state_nxt  = ST_IDLE;
               end
            end
            ST_LOCK: begin
               if (!z) begin
                  w_streak_nxt = 4'd0;
                  w_state_nxt  = ST_IDLE;
               end
            end
            default: begin
               w_streak_nxt = 4'd0;
               w_state_nxt  = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_x     <= 2'd0;
         r_out_y     <= 2'd0;
         r_out_eq    <= 1'b0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_x     <= x;
         r_out_y     <= y;
         r_out_eq    <= z;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_eq_cnt  <= '0;
         r_neq_cnt <= '0;
         r_tot_cnt <= '0;
      end else if (clr) begin
         r_eq_cnt  <= '0;
         r_neq_cnt <= '0;
         r_tot_cnt <= '0;
      end else if (w_count) begin
         r_tot_cnt <= sat_inc(r_tot_cnt);
         if (z) r_eq_cnt  <= sat_inc(r_eq_cnt);
         else   r_neq_cnt <= sat_inc(r_neq_cnt);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_streak  <= 4'd0;
         r_run_hit <= 1'b0;
      end else if (clr) begin
         r_state   <= ST_IDLE;
         r_streak  <= 4'd0;
         r_run_hit <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_streak  <= w_streak_nxt;
         r_run_hit <= w_hit_nxt;
      end
   end

   // The error is judged on every accepted beat, but clr in the same cycle wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mismatch <= 1'b0;
      end else if (clr) begin
         r_mismatch <= 1'b0;
      end else if (w_accept && (z != w_ref_eq)) begin
         r_mismatch <= 1'b1;
      end
   end

   assign in_ready     = w_in_ready;
   assign out_valid    = r_out_valid;
   assign out_x        = r_out_x;
   assign out_y        = r_out_y;
   assign out_eq       = r_out_eq;
   assign eq_count     = r_eq_cnt;
   assign neq_count    = r_neq_cnt;
   assign total_count  = r_tot_cnt;
   assign run_hit      = r_run_hit;
   assign run_active   = (r_state == ST_LOCK);
   assign mismatch_err = r_mismatch;
   assign dbg_state    = r_state;
   assign dbg_streak   = r_streak;

endmodule

// File: doc/cmp_result_tracker.md
# cmp_result_tracker

Downstream consumer of the 2-bit equality comparator (`bitwise`: operands x, y, result z). It accepts one operand pair plus its comparator result per valid/ready beat and forwards the beat through a one-entry output register. It keeps saturating equal, not-equal and total counts, and detects runs of consecutive equal results. It also cross-checks every result against its own x==y and flags any disagreement as a sticky error.

## Interface
Parameters:
- CNT_W, 8, width of each statistics counter.
- RUN_LEN, 3, number of consecutive equal beats that fires run_hit. Legal range is 2..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- x  in  2  operand A, as presented to the comparator.
- y  in  2  operand B, as presented to the comparator.
- z  in  1  comparator result (1 = equal).
- clr  in  1  synchronous clear of statistics, FSM and error flag.
- out_valid  out  1  forwarded beat valid.
- out_ready  in  1  downstream accepts the forwarded beat.
- out_x  out  2  forwarded x.
- out_y  out  2  forwarded y.
- out_eq  out  1  forwarded z.
- eq_count  out  CNT_W  number of accepted beats with z=1.
- neq_count  out  CNT_W  number of accepted beats with z=0.
- total_count  out  CNT_W  number of accepted beats.
- run_hit  out  1  one-cycle pulse when a run of RUN_LEN equal beats completes.
- run_active  out  1  high while in the LOCK state.
- mismatch_err  out  1  sticky flag: set when z != (x==y) on an accepted beat.

## Operation
- Accept condition: in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational and lets the output register take a new beat in the same cycle it is drained.
- On accept: out_x/out_y/out_eq are loaded from x/y/z and out_valid=1.
- When out_valid && out_ready and there is no accept in that cycle, out_valid clears.
- Counters:
  - On accept, total_count increments.
  - If z=1, eq_count increments; otherwise neq_count increments.
  - Each counter saturates independently at 2^CNT_W-1 and never wraps.
- Streak counter: 4 bits, internal. It saturates at RUN_LEN.
- Run FSM, stepped only on accept:
  - IDLE: z=1 → streak=1, go to RUN. z=0 → stay in IDLE.
  - RUN: z=1 → streak+1. When streak+1 == RUN_LEN: run_hit=1 for the next cycle, go to LOCK. z=0 → streak=0, go to IDLE.
  - LOCK: z=1 → stay in LOCK, no further pulses. z=0 → streak=0, go to IDLE.
  - run_active=1 only in LOCK.
- mismatch_err:
  - Set on an accept where z != (x==y).
  - Cleared only by clr or reset.
  - The beat is still forwarded and counted using z as presented.
- clr (synchronous, highest priority over counting):
  - Zeroes all counters and streak, sets FSM to IDLE, clears mismatch_err and run_hit.
  - A beat accepted in a clr cycle is still forwarded, but it is not counted and does not step the FSM.
  - clr does not touch out_valid or the output data registers.

## Timing
- Reset values: in_ready=1 (since out_valid=0), out_valid=0, out_x=0, out_y=0, out_eq=0, all counts 0, run_hit=0, run_active=0, mismatch_err=0, FSM in IDLE.
- Latency: a beat accepted at edge N is visible on out_* and out_valid after edge N, and counters reflect it after edge N.
- run_hit is registered: it is high for exactly the one cycle following the accepting edge of the RUN_LEN-th equal beat.
- Back-to-back accepts at one beat per cycle are sustained whenever out_ready=1.
- With out_valid=1 and out_ready=0: in_ready=0, and the output data is held stable until it is taken.
- Reset asserted mid-stream: all state returns to reset values immediately (asynchronous). Any pending out beat is dropped.

## Test plan
- Reset, then drive pairs (3,2,z=0), (3,3,1), (1,1,1), (1,2,0), (1,3,0) with out_ready=1 -> out beats mirror the inputs one cycle later; eq_count=2, neq_count=3, total_count=5, run_hit never fires, mismatch_err=0.
- Drive four equal beats (2,2,1) back-to-back with RUN_LEN=3 -> run_hit high for one cycle after the 3rd beat; run_active=1 through the 4th beat; run_active drops after a following (0,1,0) beat.
- Hold out_ready=0 with in_valid=1 -> first beat is accepted, then in_ready=0 and out_x/out_y stay fixed for 5 cycles; raise out_ready -> the next beat is accepted in that same cycle with no bubble.
- Drive (1,1,z=0) -> mismatch_err=1 and neq_count=1; it persists through 3 good beats; pulse clr -> all counters 0 and mismatch_err=0.
- With CNT_W=2, drive 5 equal beats -> eq_count and total_count saturate at 3.
- Assert rst_n=0 mid-run (FSM in RUN, out_valid=1) -> on the next cycle out_valid=0, counts are 0 and the FSM is in IDLE.
